alu_seq_core: RTL and testbench
===============================

Name: alu_seq_core

Overview:
Registered, parametrised successor to the switch-driven 4-bit add/sub ALU with comparator and seven-segment output.
- Operand width is generic and eight operations are supported.
- Execution is triggered by a debounced, edge-detected button; result, flags and compare are registered.
- Drives a time-multiplexed hex display.
- Sits between board switches/buttons and the seven-segment/LED pins of the lab top level.

Parameters:
WIDTH, 4, operand/result width in bits (>=2)
DEB_CYCLES, 250000, consecutive stable clocks required before the debounced button level changes (>=2)
REFRESH_CYCLES, 50000, clocks each display digit is held active (>=2)
DIGITS (localparam), ceil(WIDTH/4), number of hex digits scanned

Ports:
Clk  in  1  system clock, all logic on rising edge
Rst_n  in  1  synchronous active-low reset
Sw  in  2*WIDTH  operands: X = Sw[WIDTH-1:0], Y = Sw[2*WIDTH-1:WIDTH]
OpSel  in  3  operation select, sampled on exec
Btn0  in  1  raw asynchronous execute button, active-high
Result  out  WIDTH  registered result
Carry  out  1  add carry-out; sub borrow (X<Y unsigned); shifted-out bit for shifts; else 0
Zero  out  1  Result == 0
Ovf  out  1  signed overflow for add/sub, else 0
CompOut  out  3  {X>Y, X==Y, X<Y}, unsigned, registered on exec
Valid  out  1  one-cycle pulse, cycle after exec
SSD  out  8  active-low segments {dp,g,f,e,d,c,b,a}
An  out  DIGITS  active-low one-hot digit enable

Behaviour:
Clock and reset:
- One clock (Clk); reset is synchronous and active-low (Rst_n). Every register is sampled on the Clk rising edge while Rst_n=0.

Reset values:
- Result=0, Carry=0, Zero=1, Ovf=0, CompOut=3'b010, Valid=0.
- Debounced level=0, synchroniser flops=0, debounce/refresh counters=0, digit index=0.
- An = all ones except bit0 = 0; SSD shows "0" on digit 0.

Button path:
- Btn0 passes through a 2-flop synchroniser.
- Debounce counter increments while the synchronised level differs from the debounced level and clears to 0 when they match.
- When the counter reaches DEB_CYCLES-1 while still differing, the debounced level toggles and the counter clears.
- Exec = one-cycle pulse on the 0->1 transition of the debounced level. A held button produces exactly one exec; release produces none.

Execute:
- On the exec cycle T, Sw and OpSel are sampled combinationally and Result, flags and CompOut load at the end of T. Valid=1 during T+1 only.
- Between execs all outputs hold.
- OpSel: 000 X+Y; 001 X-Y (two's complement, mod 2^WIDTH); 010 X&Y; 011 X|Y; 100 X^Y; 101 X<<1; 110 X>>1 logical; 111 pass Y.
- Shifts: Carry = X[WIDTH-1] for shl, X[0] for shr.
- Ovf for add: operand MSBs equal and result MSB differs. For sub: operand MSBs differ and result MSB differs from X MSB.
- Zero is computed from the new Result.

Display:
- Refresh counter counts 0..REFRESH_CYCLES-1 and wraps.
- On wrap, digit index increments, wrapping DIGITS-1 -> 0.
- An[i]=0 iff index==i. Digit i shows hex of Result[4i+3:4i], zero-extended for the top digit.
- dp is lit (SSD[7]=0) only on digit 0 and only when Carry=1.
- The display uses the registered Result, so a mid-scan exec changes the shown value only from the next cycle on.

Boundaries:
- Reset asserted mid-debounce or while Btn0 is held: state clears. After reset is released with Btn0 still held, an exec fires once debounce completes, because the debounced level restarts at 0.
- Exec coinciding with a refresh wrap: both take effect; the two are independent.

Test Plan:
WIDTH=4, DEB_CYCLES=4, REFRESH_CYCLES=8.
1. X=7,Y=2, OpSel=000, press Btn0 -> exactly one Valid pulse, Result=9, Carry=0, Ovf=1, CompOut=100. Then OpSel=001, press again -> Result=5, Carry=0, Ovf=0.
2. X=5,Y=6, OpSel=001 -> Result=F, Carry=1 (borrow), CompOut=001, Zero=0, dp lit on digit 0. Then OpSel=000 -> Result=B, Carry=0.
3. Btn0 high for 3 cycles then low (bounce) -> no exec, Valid stays 0, Result unchanged. Btn0 high for 20 cycles -> exactly one Valid; Valid occurs 2 sync + 4 debounce + 1 exec cycles after the rise.
4. X=4,Y=4, OpSel=100 -> Result=0, Zero=1, CompOut=010. X=9, OpSel=101 -> Result=2, Carry=1. X=9, OpSel=110 -> Result=4, Carry=1.
5. WIDTH=8 instance, X=8'hF0,Y=8'h3C, OpSel=011 -> Result=FC. An cycles 10,01,10 every 8 clocks; SSD shows C on digit 0 and F on digit 1.
6. Rst_n=0 for one cycle while Btn0 held and Result=9 -> next cycle Result=0, Zero=1, CompOut=010, An=10. With Btn0 still held, one exec follows after debounce.

Source files
------------

// File: rtl/alu_seq_core_if.sv
// Bundle between the board pins and alu_seq_core: switch operands,
//   operation select and raw button in; registered ALU result, flags
//   and multiplexed seven-segment drive out. No flow control.
// Ports: Sw/OpSel/Btn0 (to core), Result/Carry/Zero/Ovf/CompOut/Valid/SSD/An (from core).
interface alu_seq_core_if #(
  parameter int WIDTH = 4
);
  localparam int DIGITS = (WIDTH + 3) / 4;

  logic [2*WIDTH-1:0] Sw;
  logic [2:0]         OpSel;
  logic               Btn0;
  logic [WIDTH-1:0]   Result;
  logic               Carry;
  logic               Zero;
  logic               Ovf;
  logic [2:0]         CompOut;
  logic               Valid;
  logic [7:0]         SSD;
  logic [DIGITS-1:0]  An;

  // master = board/bench side, slave = the core
  modport master (
    output Sw, OpSel, Btn0,
    input  Result, Carry, Zero, Ovf, CompOut, Valid, SSD, An
  );

  modport slave (
    input  Sw, OpSel, Btn0,
    output Result, Carry, Zero, Ovf, CompOut, Valid, SSD, An
  );
endinterface

// File: rtl/alu_seq_core.sv
// Button-triggered registered ALU with comparator and scanned hex display.
// Latency: Btn0 rise -> Valid after 2 sync + DEB_CYCLES debounce + 1 exec clocks.
// Backpressure: none; outputs hold between execs, Valid is a single-cycle pulse.
// Ports: Clk, Rst_n (sync, active-low); bus = Sw/OpSel/Btn0 in,
//   Result/Carry/Zero/Ovf/CompOut/Valid/SSD/An out.
module alu_seq_core #(
  parameter int WIDTH          = 4,
  parameter int DEB_CYCLES     = 250000,
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic          Clk,
  input  logic          Rst_n,
  alu_seq_core_if.slave bus
);
  localparam int DIGITS = (WIDTH + 3) / 4;
  localparam int DCW    = $clog2(DEB_CYCLES);
  localparam int RCW    = $clog2(REFRESH_CYCLES);
  localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // ---------------- button synchroniser / debounce / edge ----------------
  logic           sync1, sync2;
  logic           deb_lvl, deb_lvl_d;
  logic [DCW-1:0] deb_cnt;
  logic           exec;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_lvl   <= 1'b0;
      deb_lvl_d <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync1     <= bus.Btn0;
      sync2     <= sync1;
      deb_lvl_d <= deb_lvl;
      // Any sample that agrees with the current level restarts the count,
      // so only an uninterrupted run of DEB_CYCLES differing samples flips it.
      if (sync2 != deb_lvl) begin
        if (deb_cnt == DCW'(DEB_CYCLES - 1)) begin
          deb_lvl <= ~deb_lvl;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DCW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Press only; release edge is ignored.
  assign exec = deb_lvl & ~deb_lvl_d;

  // ---------------- combinational ALU ----------------
  logic [WIDTH-1:0] x, y, alu_res;
  logic [WIDTH:0]   sum_ext, dif_ext;
  logic             alu_c, alu_o;

  assign x       = bus.Sw[WIDTH-1:0];
  assign y       = bus.Sw[2*WIDTH-1:WIDTH];
  assign sum_ext = {1'b0, x} + {1'b0, y};
  // Top bit of the extended difference is the unsigned borrow (x < y).
  assign dif_ext = {1'b0, x} - {1'b0, y};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (bus.OpSel)
      3'b000: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_o   = (x[WIDTH-1] == y[WIDTH-1]) && (sum_ext[WIDTH-1] != x[WIDTH-1]);
      end
      3'b001: begin
        alu_res = dif_ext[WIDTH-1:0];
        alu_c   = dif_ext[WIDTH];
        alu_o   = (x[WIDTH-1] != y[WIDTH-1]) && (dif_ext[WIDTH-1] != x[WIDTH-1]);
      end
      3'b010: alu_res = x & y;
      3'b011: alu_res = x | y;
      3'b100: alu_res = x ^ y;
      3'b101: begin
        alu_res = {x[WIDTH-2:0], 1'b0};
        alu_c   = x[WIDTH-1];
      end
      3'b110: begin
        alu_res = {1'b0, x[WIDTH-1:1]};
        alu_c   = x[0];
      end
      default: alu_res = y;
    endcase
  end

  // ---------------- result / flag registers ----------------
  logic [WIDTH-1:0] result_q;
  logic             carry_q, zero_q, ovf_q, valid_q;
  logic [2:0]       comp_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      comp_q   <= 3'b010;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= exec;
      if (exec) begin
        result_q <= alu_res;
        carry_q  <= alu_c;
        zero_q   <= (alu_res == '0);
        ovf_q    <= alu_o;
        comp_q   <= {x > y, x == y, x < y};
      end
    end
  end

  // ---------------- display scan ----------------
  logic [RCW-1:0]    ref_cnt;
  logic [IDXW-1:0]   dig_idx;
  logic [4*DIGITS-1:0] res_pad;
  logic [3:0]        nib;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an_n;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ref_cnt <= '0;
      dig_idx <= '0;
    end else if (ref_cnt == RCW'(REFRESH_CYCLES - 1)) begin
      ref_cnt <= '0;
      dig_idx <= (dig_idx == IDXW'(DIGITS - 1)) ? '0 : dig_idx + IDXW'(1);
    end else begin
      ref_cnt <= ref_cnt + RCW'(1);
    end
  end

  // Zero-extend Result to whole nibbles so the top digit is well defined.
  always_comb begin
    res_pad              = '0;
    res_pad[WIDTH-1:0]   = result_q;
    nib                  = 4'h0;
    an_n                 = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_idx == IDXW'(i)) begin
        nib     = res_pad[4*i +: 4];
        an_n[i] = 1'b0;
      end
    end
  end

  // Active-high {g,f,e,d,c,b,a}; inverted at the output.
  always_comb begin
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
  end

  assign bus.Result  = result_q;
  assign bus.Carry   = carry_q;
  assign bus.Zero    = zero_q;
  assign bus.Ovf     = ovf_q;
  assign bus.CompOut = comp_q;
  assign bus.Valid   = valid_q;
  // Decimal point marks carry, shown on the least significant digit only.
  assign bus.SSD     = {~((dig_idx == '0) && carry_q), ~seg};
  assign bus.An      = an_n;
endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: a 4-bit and an 8-bit instance share clock and reset.
// Expected results are queued on each press and checked on every Valid pulse.
module tb_alu_seq_core;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  int   vcnt4 = 0, vcnt8 = 0;
  int   last_v4 = 0, last_v8 = 0;
  int   rise_cyc = 0;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       o;
    logic [2:0] cmp;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  alu_seq_core_if #(.WIDTH(4)) b4();
  alu_seq_core_if #(.WIDTH(8)) b8();

  alu_seq_core #(.WIDTH(4), .DEB_CYCLES(4), .REFRESH_CYCLES(8)) dut4 (
    .Clk(clk), .Rst_n(rst_n), .bus(b4)
  );
  alu_seq_core #(.WIDTH(8), .DEB_CYCLES(4), .REFRESH_CYCLES(8)) dut8 (
    .Clk(clk), .Rst_n(rst_n), .bus(b8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sgn(input int v, input int w);
    int m;
    m = 1 << w;
    return (v >= m / 2) ? v - m : v;
  endfunction

  // Arithmetic reference in plain integers.
  function automatic exp_t model(input int w, input int x, input int y, input int op);
    exp_t e;
    int   m, r, s;
    m = 1 << w;
    r = 0;
    s = 0;
    e.c = 1'b0;
    e.o = 1'b0;
    case (op)
      0: begin
        r = x + y; e.c = (r >= m); r = r % m;
        s = sgn(x, w) + sgn(y, w); e.o = (s > m / 2 - 1) || (s < -(m / 2));
      end
      1: begin
        r = (x - y + m) % m; e.c = (x < y);
        s = sgn(x, w) - sgn(y, w); e.o = (s > m / 2 - 1) || (s < -(m / 2));
      end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: begin r = (x * 2) % m; e.c = (x >= m / 2); end
      6: begin r = x / 2; e.c = (x % 2 == 1); end
      default: r = y;
    endcase
    e.res = 8'(r);
    e.z   = (r == 0);
    e.cmp = {x > y, x == y, x < y};
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && b4.Valid === 1'b1) begin
      vcnt4++;
      last_v4 = cyc;
      if (q4.size() == 0) chk("valid4_unexpected", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        chk("res4",  32'(b4.Result),  32'(e.res[3:0]));
        chk("c4",    32'(b4.Carry),   32'(e.c));
        chk("z4",    32'(b4.Zero),    32'(e.z));
        chk("o4",    32'(b4.Ovf),     32'(e.o));
        chk("cmp4",  32'(b4.CompOut), 32'(e.cmp));
      end
    end
    if (rst_n === 1'b1 && b8.Valid === 1'b1) begin
      vcnt8++;
      last_v8 = cyc;
      if (q8.size() == 0) chk("valid8_unexpected", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        chk("res8",  32'(b8.Result),  32'(e.res));
        chk("c8",    32'(b8.Carry),   32'(e.c));
        chk("z8",    32'(b8.Zero),    32'(e.z));
        chk("o8",    32'(b8.Ovf),     32'(e.o));
        chk("cmp8",  32'(b8.CompOut), 32'(e.cmp));
      end
    end
  end

  // Hold the button for 'hold' clocks, release, and let the release settle.
  task automatic press(input int sel, input int hold, input bit expect_exec);
    int x, y, op;
    if (sel == 0) begin
      x = int'(b4.Sw[3:0]); y = int'(b4.Sw[7:4]); op = int'(b4.OpSel);
      if (expect_exec) q4.push_back(model(4, x, y, op));
    end else begin
      x = int'(b8.Sw[7:0]); y = int'(b8.Sw[15:8]); op = int'(b8.OpSel);
      if (expect_exec) q8.push_back(model(8, x, y, op));
    end
    @(posedge clk); #1;
    if (sel == 0) b4.Btn0 = 1'b1; else b8.Btn0 = 1'b1;
    rise_cyc = cyc;
    repeat (hold) @(posedge clk);
    #1;
    if (sel == 0) b4.Btn0 = 1'b0; else b8.Btn0 = 1'b0;
    repeat (14) @(posedge clk);
    #1;
  endtask

  task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic [2:0] op);
    int v;
    b4.Sw = {y, x};
    b4.OpSel = op;
    v = vcnt4;
    press(0, 20, 1'b1);
    chk("one_valid4", 32'(vcnt4 - v), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int prev, cur;
    bit found;
    rst_n = 1'b0;
    b4.Sw = '0; b4.OpSel = '0; b4.Btn0 = 1'b0;
    b8.Sw = '0; b8.OpSel = '0; b8.Btn0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res",   32'(b4.Result),  32'd0);
    chk("rst_carry", 32'(b4.Carry),   32'd0);
    chk("rst_zero",  32'(b4.Zero),    32'd1);
    chk("rst_ovf",   32'(b4.Ovf),     32'd0);
    chk("rst_cmp",   32'(b4.CompOut), 32'b010);
    chk("rst_valid", 32'(b4.Valid),   32'd0);
    chk("rst_an4",   32'(b4.An),      32'd0);
    chk("rst_ssd4",  32'(b4.SSD),     32'hC0);
    chk("rst_an8",   32'(b8.An),      32'b10);
    chk("rst_ssd8",  32'(b8.SSD),     32'hC0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // add with signed overflow, then subtract
    run4(4'd7, 4'd2, 3'b000);
    chk("t1_res", 32'(b4.Result), 32'h9);
    chk("t1_ovf", 32'(b4.Ovf), 32'd1);
    chk("t1_cmp", 32'(b4.CompOut), 32'b100);
    run4(4'd7, 4'd2, 3'b001);
    chk("t1b_res", 32'(b4.Result), 32'h5);

    // borrow lights dp on digit 0
    run4(4'd5, 4'd6, 3'b001);
    chk("t2_res", 32'(b4.Result), 32'hF);
    chk("t2_borrow", 32'(b4.Carry), 32'd1);
    chk("t2_ssd", 32'(b4.SSD), 32'h0E);
    run4(4'd5, 4'd6, 3'b000);
    chk("t2b_res", 32'(b4.Result), 32'hB);
    chk("t2b_ssd", 32'(b4.SSD), 32'h83);

    // short bounce must not execute
    b4.OpSel = 3'b010;
    v = vcnt4;
    press(0, 3, 1'b0);
    chk("t3_bounce_valid", 32'(vcnt4 - v), 32'd0);
    chk("t3_bounce_hold", 32'(b4.Result), 32'hB);
    v = vcnt4;
    press(0, 20, 1'b1);
    chk("t3_one_valid", 32'(vcnt4 - v), 32'd1);
    chk("t3_latency", 32'(last_v4 - rise_cyc), 32'd7);
    chk("t3_res", 32'(b4.Result), 32'h4);

    // xor to zero, shifts
    run4(4'd4, 4'd4, 3'b100);
    chk("t4_zero", 32'(b4.Zero), 32'd1);
    chk("t4_cmp", 32'(b4.CompOut), 32'b010);
    run4(4'd9, 4'd4, 3'b101);
    chk("t4_shl", 32'(b4.Result), 32'h2);
    chk("t4_shl_c", 32'(b4.Carry), 32'd1);
    run4(4'd9, 4'd4, 3'b110);
    chk("t4_shr", 32'(b4.Result), 32'h4);
    chk("t4_shr_c", 32'(b4.Carry), 32'd1);

    // every op with random operands
    for (int op = 0; op < 8; op++)
      run4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'(op));

    // reset while button held mid-debounce
    run4(4'd7, 4'd2, 3'b000);
    @(posedge clk); #1;
    b4.Btn0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_res", 32'(b4.Result), 32'd0);
    chk("t6_zero", 32'(b4.Zero), 32'd1);
    chk("t6_cmp", 32'(b4.CompOut), 32'b010);
    chk("t6_an8", 32'(b8.An), 32'b10);
    rst_n = 1'b1;
    b4.Sw = {4'd2, 4'd3};
    q4.push_back(model(4, 3, 2, 0));
    rise_cyc = cyc;
    v = vcnt4;
    repeat (20) @(posedge clk);
    #1;
    b4.Btn0 = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("t6_one_valid", 32'(vcnt4 - v), 32'd1);
    chk("t6_latency", 32'(last_v4 - rise_cyc), 32'd7);
    chk("t6_res_after", 32'(b4.Result), 32'h5);

    // 8-bit instance: OR, overflow add, then display scan
    b8.Sw = {8'h01, 8'h7F}; b8.OpSel = 3'b000;
    v = vcnt8;
    press(1, 20, 1'b1);
    chk("t5_add_valid", 32'(vcnt8 - v), 32'd1);
    chk("t5_add_ovf", 32'(b8.Ovf), 32'd1);
    b8.Sw = {8'h3C, 8'hF0}; b8.OpSel = 3'b011;
    v = vcnt8;
    press(1, 20, 1'b1);
    chk("t5_or_valid", 32'(vcnt8 - v), 32'd1);
    chk("t5_res", 32'(b8.Result), 32'hFC);

    @(negedge clk);
    prev = int'(b8.An);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (int'(b8.An) != prev) found = 1'b1;
    end
    chk("t5_scan_found", 32'(found), 32'd1);
    if (found) begin
      for (int k = 0; k < 2; k++) begin
        cur = int'(b8.An);
        chk("t5_an_onehot", 32'(cur == 2 || cur == 1), 32'd1);
        chk("t5_ssd", 32'(b8.SSD), (cur == 2) ? 32'hC6 : 32'h8E);
        for (int i = 1; i < 8; i++) begin
          @(negedge clk);
          chk("t5_an_hold", 32'(b8.An), 32'(cur));
        end
        @(negedge clk);
        chk("t5_an_next", 32'(b8.An), 32'(3 - cur));
      end
    end

    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
